npem_command_sequencer: RTL and testbench
=========================================

# npem_command_sequencer

Downstream companion of the NPEM control register. Every accepted control-register write becomes one command to the enclosure backend over a req/ack handshake, or an enclosure reset when NPEM Initiate Reset was written. When the backend acknowledges or a watchdog expires, the block sets the sticky NPEM Command Completed (and Timeout) status bits and pulses an interrupt request.

## Interface
- REGISTER_WIDTH, 32, width of the control value and the enclosure command bus
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles for an outstanding request; must be ≥ 2
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- ctrl_write  in  1  pulse, same cycle as an accepted control-register write
- ctrl_value  in  REGISTER_WIDTH  control-register read_data; reflects the new value the cycle after ctrl_write; bit 0 = NPEM enable
- npem_reset_initiated  in  1  registered reset-request pulse; high in the cycle after ctrl_write
- cmd_int_enable  in  1  enables irq generation
- status_write  in  1  status-register write strobe
- status_write_data  in  REGISTER_WIDTH  RW1C data; bit 0 clears cmd_completed, bit 1 clears cmd_timeout
- enc_ack  in  1  backend acknowledge for enc_req or enc_reset
- enc_req  out  1  command request, held until ack or timeout
- enc_cmd  out  REGISTER_WIDTH  captured command, stable while enc_req = 1
- enc_reset  out  1  enclosure reset request, held until ack or timeout
- busy  out  1  high in every state except IDLE
- cmd_completed  out  1  sticky Command Completed status
- cmd_timeout  out  1  sticky, set when completion came from the watchdog
- irq  out  1  one-cycle pulse on each completion while cmd_int_enable = 1

## Operation
- States: IDLE, CAPTURE, ISSUE, RESET.
- IDLE:
  - ctrl_write or pending = 1 -> CAPTURE; clear pending.
- CAPTURE (one cycle):
  - npem_reset_initiated = 1 -> RESET.
  - Else ctrl_value[0] = 0 (NPEM disabled) -> completion without a handshake; -> IDLE.
  - Else enc_cmd <= ctrl_value; -> ISSUE.
- ISSUE: enc_req = 1; the watchdog counts each cycle starting at 0.
  - enc_ack -> completion; -> IDLE.
  - Counter == TIMEOUT_CYCLES-1 without ack -> completion plus cmd_timeout set; -> IDLE.
- RESET: enc_reset = 1; the watchdog restarts at 0; exits on ack or timeout with the same completion rules as ISSUE.
- Completion: sets cmd_completed, sets cmd_timeout when watchdog-caused, and pulses irq if cmd_int_enable.
- pending (1-deep flag): set by ctrl_write in CAPTURE, ISSUE or RESET. Extra writes merge into it, so the latest ctrl_value wins.
- Reset abort: npem_reset_initiated while in ISSUE drops enc_req the next cycle and enters RESET. The watchdog restarts at 0. No completion is reported for the aborted command.
- RW1C: status_write clears the bits selected by status_write_data. A completion set in the same cycle wins over the clear.
- enc_ack outside ISSUE/RESET is ignored.

## Timing
- Reset values: state IDLE; enc_req, enc_reset, busy, cmd_completed, cmd_timeout, irq, pending = 0; enc_cmd = 0; counter = 0.
- All outputs are registered.
- Normal command:
  - ctrl_write at cycle T; CAPTURE at T+1; enc_req and busy high from T+2.
  - enc_ack sampled at cycle A: enc_req low, cmd_completed high and irq pulse at A+1.
  - busy low at A+1, unless pending sends the FSM to CAPTURE.
- Disabled command: completion and irq at T+2; enc_req never asserted.
- Timeout: enc_req high for exactly TIMEOUT_CYCLES cycles, then drops together with the cmd_completed/cmd_timeout set.
- Simultaneous events:
  - ack in the same cycle as the counter limit -> ack wins; no timeout flag.
  - reset pulse in the same cycle as ack in ISSUE -> the reset wins; no completion.
- rst_n deasserted mid-handshake: enc_req/enc_reset drop immediately (asynchronous); the next command restarts from IDLE.

## Test plan
- Write ctrl_value=0x0000_0005, enc_ack 3 cycles after enc_req -> enc_cmd=0x0000_0005 from T+2; cmd_completed=1, irq one cycle, busy=0 at A+1.
- Write with bit0=0 -> no enc_req; cmd_completed=1 at T+2; then status_write data=0x1 -> cmd_completed=0 the next cycle.
- TIMEOUT_CYCLES=8, never ack -> enc_req high 8 cycles; cmd_completed=1, cmd_timeout=1; clearing with data=0x2 leaves cmd_completed=1.
- Pulse npem_reset_initiated while enc_req is high -> enc_req low next cycle; enc_reset high until ack; exactly one completion.
- Two ctrl_write pulses during ISSUE with distinct values -> exactly one follow-up command; enc_cmd equals the last value.
- rst_n low while enc_req is high -> all outputs 0 immediately; a new write completes normally afterwards.

Source files
------------

// File: rtl/npem_command_sequencer_if.sv
// Handshake bundle between the NPEM control/status registers, the command
// sequencer and the enclosure backend.
interface npem_command_sequencer_if #(
   parameter int REGISTER_WIDTH = 32
);
   logic                      ctrl_write;
   logic [REGISTER_WIDTH-1:0] ctrl_value;
   logic                      npem_reset_initiated;
   logic                      cmd_int_enable;
   logic                      status_write;
   logic [REGISTER_WIDTH-1:0] status_write_data;
   logic                      enc_ack;
   logic                      enc_req;
   logic [REGISTER_WIDTH-1:0] enc_cmd;
   logic                      enc_reset;
   logic                      busy;
   logic                      cmd_completed;
   logic                      cmd_timeout;
   logic                      irq;

   // enc_req/enc_reset are levels held by the sequencer until the backend
   // answers with a one-cycle enc_ack or the watchdog expires; an ack seen
   // while neither request is raised carries no meaning and is dropped.
   modport master (
      output ctrl_write, ctrl_value, npem_reset_initiated, cmd_int_enable,
             status_write, status_write_data, enc_ack,
      input  enc_req, enc_cmd, enc_reset, busy, cmd_completed, cmd_timeout, irq
   );

   modport slave (
      input  ctrl_write, ctrl_value, npem_reset_initiated, cmd_int_enable,
             status_write, status_write_data, enc_ack,
      output enc_req, enc_cmd, enc_reset, busy, cmd_completed, cmd_timeout, irq
   );
endinterface

// File: rtl/npem_command_sequencer.sv
// Turns each accepted NPEM control write into one enclosure command or reset
// and reports completion/timeout through sticky RW1C status and an irq pulse.
module npem_command_sequencer #(
   parameter int REGISTER_WIDTH = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     rst_n,
   npem_command_sequencer_if.slave  bus,
   output logic [1:0]               o_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_ISSUE   = 2'd2,
      S_RESET   = 2'd3
   } state_t;

   localparam int          CW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   state_t                    r_state;
   logic [CW-1:0]             r_cnt;
   logic                      r_pending;
   logic                      r_enc_req;
   logic                      r_enc_reset;
   logic [REGISTER_WIDTH-1:0] r_enc_cmd;
   logic                      r_busy;
   logic                      r_completed;
   logic                      r_timeout;
   logic                      r_irq;

   logic w_ack_done;
   logic w_wd_done;
   logic w_cap_done;
   logic w_complete;
   logic w_pend;
   logic w_unused_status_bits;

   assign w_unused_status_bits = ^bus.status_write_data[REGISTER_WIDTH-1:2];

   // A reset pulse in ISSUE aborts the command, so it masks ack and watchdog.
   always_comb begin
      w_ack_done = 1'b0;
      w_wd_done  = 1'b0;
      w_cap_done = 1'b0;
      case (r_state)
         S_CAPTURE: w_cap_done = !bus.npem_reset_initiated && !bus.ctrl_value[0];
         S_ISSUE: begin
            if (!bus.npem_reset_initiated) begin
               if (bus.enc_ack)       w_ack_done = 1'b1;
               else if (r_cnt == LIMIT) w_wd_done = 1'b1;
            end
         end
         S_RESET: begin
            if (bus.enc_ack)         w_ack_done = 1'b1;
            else if (r_cnt == LIMIT) w_wd_done  = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_complete = w_ack_done | w_wd_done | w_cap_done;
   assign w_pend     = r_pending | bus.ctrl_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_pending   <= 1'b0;
         r_enc_req   <= 1'b0;
         r_enc_reset <= 1'b0;
         r_enc_cmd   <= '0;
         r_busy      <= 1'b0;
         r_completed <= 1'b0;
         r_timeout   <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_irq <= w_complete & bus.cmd_int_enable;

         if (w_complete)                                     r_completed <= 1'b1;
         else if (bus.status_write && bus.status_write_data[0]) r_completed <= 1'b0;

         if (w_wd_done)                                      r_timeout <= 1'b1;
         else if (bus.status_write && bus.status_write_data[1]) r_timeout <= 1'b0;

         // A finished request goes straight back to CAPTURE when a write is queued.
         if (w_complete) begin
            r_state     <= w_pend ? S_CAPTURE : S_IDLE;
            r_busy      <= w_pend;
            r_pending   <= 1'b0;
            r_enc_req   <= 1'b0;
            r_enc_reset <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_pend) begin
                     r_state   <= S_CAPTURE;
                     r_busy    <= 1'b1;
                     r_pending <= 1'b0;
                  end
               end
               S_CAPTURE: begin
                  r_pending <= w_pend;
                  r_cnt     <= '0;
                  if (bus.npem_reset_initiated) begin
                     r_state     <= S_RESET;
                     r_enc_reset <= 1'b1;
                  end else begin
                     r_state   <= S_ISSUE;
                     r_enc_cmd <= bus.ctrl_value;
                     r_enc_req <= 1'b1;
                  end
               end
               S_ISSUE: begin
                  r_pending <= w_pend;
                  if (bus.npem_reset_initiated) begin
                     r_state     <= S_RESET;
                     r_enc_req   <= 1'b0;
                     r_enc_reset <= 1'b1;
                     r_cnt       <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               S_RESET: begin
                  r_pending <= w_pend;
                  r_cnt     <= r_cnt + 1'b1;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.enc_req       = r_enc_req;
   assign bus.enc_cmd       = r_enc_cmd;
   assign bus.enc_reset     = r_enc_reset;
   assign bus.busy          = r_busy;
   assign bus.cmd_completed = r_completed;
   assign bus.cmd_timeout   = r_timeout;
   assign bus.irq           = r_irq;
   assign o_state           = r_state;

endmodule

// File: tb/tb_npem_command_sequencer.sv
// Bench for npem_command_sequencer: vector table of single commands plus
// hand-written abort, merge, RW1C and asynchronous-reset sequences.
module tb_npem_command_sequencer;

   localparam int W  = 32;
   localparam int TO = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] dbg_state;

   npem_command_sequencer_if #(.REGISTER_WIDTH(W)) bus();

   npem_command_sequencer #(
      .REGISTER_WIDTH(W),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .o_state (dbg_state)
   );

   always #5 clk = ~clk;

   int           n_checks  = 0;
   int           n_errors  = 0;
   int           irq_seen  = 0;
   int           req_rises = 0;
   logic         prev_req  = 1'b0;
   logic [W-1:0] exp_q[$];

   typedef struct {
      logic [W-1:0] value;
      int           ack_dly;   // -1: backend never answers
      logic         int_en;
      logic         exp_req;
      logic         exp_to;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Every rising enc_req must match the next queued command.
   always @(negedge clk) begin
      if (bus.enc_req && !prev_req) begin
         req_rises++;
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_cmd: got %h expected none", bus.enc_cmd);
         end else begin
            check("enc_cmd_at_req", bus.enc_cmd, exp_q.pop_front());
         end
      end
      if (bus.irq) irq_seen++;
      prev_req = bus.enc_req;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr(input logic [W-1:0] d);
      bus.status_write      = 1'b1;
      bus.status_write_data = d;
      step();
      bus.status_write      = 1'b0;
      bus.status_write_data = '0;
   endtask

   // Returns at cycle T+2 relative to the ctrl_write cycle T.
   task automatic do_write(input logic [W-1:0] v, input logic rst_bit);
      if (v[0] && !rst_bit) exp_q.push_back(v);
      bus.ctrl_write = 1'b1;
      step();
      bus.ctrl_write           = 1'b0;
      bus.ctrl_value           = v;
      bus.npem_reset_initiated = rst_bit;
      step();
      bus.npem_reset_initiated = 1'b0;
   endtask

   task automatic wait_req(input int max_cycles);
      int n = 0;
      while (!bus.enc_req && n < max_cycles) begin
         step();
         n++;
      end
      check("wait_req", {31'd0, bus.enc_req}, 32'd1);
   endtask

   task automatic ack_now();
      bus.enc_ack = 1'b1;
      step();
      bus.enc_ack = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench timed out");
   end

   initial begin
      int base_irq;
      int base_rise;
      int hi_cnt;

      vecs[0] = '{value: 32'h0000_0005, ack_dly: 3,  int_en: 1'b1, exp_req: 1'b1, exp_to: 1'b0};
      vecs[1] = '{value: 32'h0000_0004, ack_dly: 0,  int_en: 1'b1, exp_req: 1'b0, exp_to: 1'b0};
      vecs[2] = '{value: 32'hA5A5_0001, ack_dly: 0,  int_en: 1'b1, exp_req: 1'b1, exp_to: 1'b0};
      vecs[3] = '{value: 32'h0000_0003, ack_dly: TO-1, int_en: 1'b1, exp_req: 1'b1, exp_to: 1'b0};
      vecs[4] = '{value: 32'h0000_0041, ack_dly: 2,  int_en: 1'b0, exp_req: 1'b1, exp_to: 1'b0};
      vecs[5] = '{value: 32'hFFFF_FFFF, ack_dly: -1, int_en: 1'b1, exp_req: 1'b1, exp_to: 1'b1};

      rst_n                    = 1'b0;
      bus.ctrl_write           = 1'b0;
      bus.ctrl_value           = '0;
      bus.npem_reset_initiated = 1'b0;
      bus.cmd_int_enable       = 1'b1;
      bus.status_write         = 1'b0;
      bus.status_write_data    = '0;
      bus.enc_ack              = 1'b0;

      #12;
      check("rst_enc_req",   {31'd0, bus.enc_req},       32'd0);
      check("rst_enc_reset", {31'd0, bus.enc_reset},     32'd0);
      check("rst_busy",      {31'd0, bus.busy},          32'd0);
      check("rst_completed", {31'd0, bus.cmd_completed}, 32'd0);
      check("rst_irq",       {31'd0, bus.irq},           32'd0);
      check("rst_enc_cmd",   bus.enc_cmd,                32'd0);
      check("rst_state",     {30'd0, dbg_state},         32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Stray ack while idle must not complete anything.
      ack_now();
      step();
      check("idle_ack_completed", {31'd0, bus.cmd_completed}, 32'd0);
      check("idle_ack_busy",      {31'd0, bus.busy},          32'd0);

      for (int i = 0; i < 6; i++) begin
         clr(32'h3);
         bus.cmd_int_enable = vecs[i].int_en;
         do_write(vecs[i].value, 1'b0);
         check($sformatf("v%0d_req", i), {31'd0, bus.enc_req}, {31'd0, vecs[i].exp_req});
         if (vecs[i].exp_req) begin
            check($sformatf("v%0d_busy", i), {31'd0, bus.busy}, 32'd1);
            check($sformatf("v%0d_cmd", i),  bus.enc_cmd,        vecs[i].value);
            if (vecs[i].ack_dly < 0) begin
               hi_cnt = 0;
               while (bus.enc_req && hi_cnt < 4 * TO) begin
                  hi_cnt++;
                  step();
               end
               check($sformatf("v%0d_req_cycles", i), hi_cnt, TO);
            end else begin
               repeat (vecs[i].ack_dly) step();
               ack_now();
               check($sformatf("v%0d_req_drop", i), {31'd0, bus.enc_req}, 32'd0);
            end
         end
         check($sformatf("v%0d_completed", i), {31'd0, bus.cmd_completed}, 32'd1);
         check($sformatf("v%0d_timeout", i),   {31'd0, bus.cmd_timeout},   {31'd0, vecs[i].exp_to});
         check($sformatf("v%0d_irq", i),       {31'd0, bus.irq},           {31'd0, vecs[i].int_en});
         check($sformatf("v%0d_busy_end", i),  {31'd0, bus.busy},          32'd0);
         step();
         check($sformatf("v%0d_irq_once", i),  {31'd0, bus.irq},           32'd0);
      end
      bus.cmd_int_enable = 1'b1;

      // RW1C: timeout bit clears alone, then completed bit.
      clr(32'h2);
      check("rw1c_to_cleared",  {31'd0, bus.cmd_timeout},   32'd0);
      check("rw1c_cc_kept",     {31'd0, bus.cmd_completed}, 32'd1);
      clr(32'h1);
      check("rw1c_cc_cleared",  {31'd0, bus.cmd_completed}, 32'd0);

      // Completion wins over a clear in the same cycle.
      do_write(32'h0000_0003, 1'b0);
      bus.status_write      = 1'b1;
      bus.status_write_data = 32'h1;
      ack_now();
      bus.status_write      = 1'b0;
      bus.status_write_data = '0;
      check("set_wins_clear", {31'd0, bus.cmd_completed}, 32'd1);
      clr(32'h3);

      // Reset abort coinciding with ack: reset wins, then exactly one completion.
      base_irq = irq_seen;
      do_write(32'h0000_0009, 1'b0);
      step();
      step();
      bus.npem_reset_initiated = 1'b1;
      bus.enc_ack              = 1'b1;
      step();
      bus.npem_reset_initiated = 1'b0;
      bus.enc_ack              = 1'b0;
      check("abort_req_low",   {31'd0, bus.enc_req},       32'd0);
      check("abort_reset_hi",  {31'd0, bus.enc_reset},     32'd1);
      check("abort_no_cc",     {31'd0, bus.cmd_completed}, 32'd0);
      repeat (3) step();
      check("abort_reset_held", {31'd0, bus.enc_reset},    32'd1);
      ack_now();
      check("abort_reset_drop", {31'd0, bus.enc_reset},    32'd0);
      check("abort_cc",         {31'd0, bus.cmd_completed}, 32'd1);
      repeat (4) step();
      check("abort_one_irq", irq_seen - base_irq, 32'd1);
      clr(32'h3);

      // Two writes during ISSUE merge into one follow-up with the last value.
      base_rise = req_rises;
      base_irq  = irq_seen;
      do_write(32'h0000_0011, 1'b0);
      bus.ctrl_write = 1'b1;
      step();
      bus.ctrl_write = 1'b0;
      bus.ctrl_value = 32'h0000_0021;
      step();
      bus.ctrl_write = 1'b1;
      step();
      bus.ctrl_write = 1'b0;
      bus.ctrl_value = 32'h0000_0041;
      exp_q.push_back(32'h0000_0041);
      step();
      ack_now();
      wait_req(20);
      check("merge_cmd", bus.enc_cmd, 32'h0000_0041);
      ack_now();
      repeat (10) step();
      check("merge_rises", req_rises - base_rise, 32'd2);
      check("merge_irqs",  irq_seen - base_irq,   32'd2);
      check("merge_busy",  {31'd0, bus.busy},     32'd0);

      // Asynchronous reset mid-handshake.
      do_write(32'h0000_0007, 1'b0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_req",  {31'd0, bus.enc_req},       32'd0);
      check("arst_busy", {31'd0, bus.busy},          32'd0);
      check("arst_cc",   {31'd0, bus.cmd_completed}, 32'd0);
      check("arst_cmd",  bus.enc_cmd,                32'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      do_write(32'h0000_0015, 1'b0);
      check("post_rst_req", {31'd0, bus.enc_req}, 32'd1);
      step();
      ack_now();
      check("post_rst_cc",  {31'd0, bus.cmd_completed}, 32'd1);
      check("post_rst_irq", {31'd0, bus.irq},           32'd1);
      step();
      check("exp_q_empty", exp_q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
